nco_sine: RTL and testbench

- Parametrised numerically controlled oscillator that generates signed sine samples for the audio/DSP datapath.
- Successor to the fixed 64-entry sine lookup. Adds a phase accumulator, a runtime frequency tuning word and a phase offset.
- Stores only a quarter-wave table, using half-sample-offset symmetry, so both half-cycles are exactly mirrored.
- Produces one sample per sample_tick on a valid/ready output, with overrun detection.

---
 rtl/nco_pkg.sv | 74 +++++++
 rtl/nco_sine_rom.sv | 40 ++++
 rtl/nco_sine.sv | 166 ++++++++++++++++
 tb/tb_nco_sine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
//
// Shared definitions for the nco_sine oscillator:
//   - default parameter values for the oscillator and its quarter-wave table
//   - quad_e        : the four sine quadrants, selected by the top two phase bits
//   - fold_t / fold : maps a quadrant to {neg, mirror}. The table index is
//                     mirrored (i -> ~i) when mirror is set, and the table
//                     value is negated when neg is set.
//   - quarter_sine  : elaboration-time constant function that produces one
//                     quarter-wave table entry,
//                       round(amplitude * sin((k + 0.5) * pi / 2^(addr_w+1)))
//                     using 128-bit Q60 fixed point.
// -----------------------------------------------------------------------------
package nco_pkg;

    localparam int PHASE_W_DEF    = 24;
    localparam int LUT_ADDR_W_DEF = 6;
    localparam int DATA_W_DEF     = 16;
    localparam int AMPLITUDE_DEF  = 32000;

    // Quadrant = phase[PHASE_W-1 -: 2].
    typedef enum logic [1:0] {
        Q0_RISE     = 2'd0,  //  rom[i]
        Q1_FALL     = 2'd1,  //  rom[~i]
        Q2_NEG_FALL = 2'd2,  // -rom[i]
        Q3_NEG_RISE = 2'd3   // -rom[~i]
    } quad_e;

    typedef struct packed {
        logic neg;
        logic mirror;
    } fold_t;

    function automatic fold_t fold(input quad_e q);
        fold_t f;
        f.neg    = 1'b0;
        f.mirror = 1'b0;
        case (q)
            Q0_RISE:     begin f.neg = 1'b0; f.mirror = 1'b0; end
            Q1_FALL:     begin f.neg = 1'b0; f.mirror = 1'b1; end
            Q2_NEG_FALL: begin f.neg = 1'b1; f.mirror = 1'b0; end
            Q3_NEG_RISE: begin f.neg = 1'b1; f.mirror = 1'b1; end
            default:     begin f.neg = 1'b0; f.mirror = 1'b0; end
        endcase
        return f;
    endfunction

    // pi in Q60 (hex expansion 3.243F6A8885A308D...).
    localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

    // Table entry k of a 2^addr_w quarter-wave table. The angle is sampled at
    // half-step offsets so entry 0 and entry 2^addr_w-1 are symmetric about
    // the quadrant edges; this keeps every entry strictly between 0 and
    // amplitude, so negation of an entry can never overflow.
    // Taylor series in Q60: for |x| < pi/2 the 12-term truncation error is far
    // below 2^-60, so the final rounding matches real-valued arithmetic.
    function automatic int quarter_sine(input int k, input int addr_w, input int amplitude);
        logic signed [127:0] x;
        logic signed [127:0] x2;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        x    = (128'(2 * k + 1) * PI_Q60) >>> (addr_w + 2);
        x2   = (x * x) >>> 60;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -((term * x2) >>> 60) / (128'(2 * n) * 128'(2 * n + 1));
            sum  = sum + term;
        end
        return int'((sum * 128'(amplitude) + (128'sd1 <<< 59)) >>> 60);
    endfunction

endpackage

// File: rtl/nco_sine_rom.sv
// -----------------------------------------------------------------------------
// quarter_sine_rom
//
// Synchronous-read quarter-wave sine table. Holds 2^LUT_ADDR_W unsigned
// magnitudes of width DATA_W-1; the sign is applied downstream.
// Contents are built at elaboration by nco_pkg::quarter_sine, so the table
// always tracks LUT_ADDR_W and AMPLITUDE without an external data file.
// The read register has no reset so the table can map onto block ROM.
//
// Ports:
//   clk   in   1             clock
//   addr  in   LUT_ADDR_W    table index
//   data  out  DATA_W-1      registered table value (one-cycle read latency)
// -----------------------------------------------------------------------------
module quarter_sine_rom
    import nco_pkg::*;
#(
    parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int AMPLITUDE  = AMPLITUDE_DEF
) (
    input  logic                  clk,
    input  logic [LUT_ADDR_W-1:0] addr,
    output logic [DATA_W-2:0]     data
);

    localparam int DEPTH = 1 << LUT_ADDR_W;

    logic [DATA_W-2:0] table_w [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        localparam int VALUE = quarter_sine(k, LUT_ADDR_W, AMPLITUDE);
        assign table_w[k] = VALUE[DATA_W-2:0];
    end

    always_ff @(posedge clk) begin
        data <= table_w[addr];
    end

endmodule

// File: rtl/nco_sine.sv
// -----------------------------------------------------------------------------
// nco_sine
//
// Numerically controlled oscillator producing signed sine samples.
// A PHASE_W-bit accumulator advances by the active tuning word on every
// accepted tick (en && sample_tick); the sample phase is acc + phase_offset.
// The top LUT_ADDR_W+2 phase bits are folded onto a quarter-wave table.
//
// Pipeline (tick sampled at edge n):
//   edge n   : stage 0 - phase captured (p0, v0), accumulator advanced,
//              ftw_active <= ftw_shadow
//   edge n+1 : stage 1 - registered table read + negate flag (v1)
//   edge n+2 : stage 2 - out_data / out_valid
// The pipeline never stalls so the accumulator always keeps real-time phase.
//
// Output handshake: out_data is offered while out_valid is high and is held
// stable until a cycle with out_valid && out_ready, which consumes it. A new
// stage-2 load always replaces the held sample; if that happens while a sample
// is held and not being consumed, the sticky overrun flag is set. A load in
// the same cycle as a consumption is a normal hand-over.
//
// Ports:
//   clk           in   1        clock
//   rst_n         in   1        asynchronous active-low reset
//   en            in   1        gates sample_tick
//   sample_tick   in   1        request next sample
//   ftw           in   PHASE_W  frequency tuning word
//   ftw_we        in   1        load ftw into the shadow register
//   phase_offset  in   PHASE_W  phase added at every lookup
//   sync_clr      in   1        accumulator clear / phase resync
//   overrun_clr   in   1        clear sticky overrun
//   out_data      out  DATA_W   signed sample
//   out_valid     out  1        out_data valid
//   out_ready     in   1        consumer accepts out_data
//   overrun       out  1        sticky: an unconsumed sample was overwritten
// -----------------------------------------------------------------------------
module nco_sine
    import nco_pkg::*;
#(
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int AMPLITUDE  = AMPLITUDE_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      sample_tick,
    input  logic [PHASE_W-1:0]        ftw,
    input  logic                      ftw_we,
    input  logic [PHASE_W-1:0]        phase_offset,
    input  logic                      sync_clr,
    input  logic                      overrun_clr,
    output logic signed [DATA_W-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun
);

    localparam int TOP_W = LUT_ADDR_W + 2;

    // ---------------------------------------------------------------- stage 0
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] ftw_shadow;
    logic [PHASE_W-1:0] ftw_active;
    logic [PHASE_W-1:0] acc_base;
    logic [PHASE_W-1:0] p_full;
    logic [TOP_W-1:0]   p0;
    logic               v0;
    logic               tick_ok;
    logic               unused_p_bits;

    assign tick_ok  = en & sample_tick;
    // sync_clr makes the current lookup start from phase 0 as well.
    assign acc_base = sync_clr ? '0 : acc;
    assign p_full   = acc_base + phase_offset;
    // Bits below the table index are truncated (no dither).
    assign unused_p_bits = ^p_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            ftw_shadow <= '0;
            ftw_active <= '0;
            p0         <= '0;
            v0         <= 1'b0;
        end else begin
            if (ftw_we) begin
                ftw_shadow <= ftw;
            end
            v0 <= tick_ok;
            if (tick_ok) begin
                p0  <= p_full[PHASE_W-1 -: TOP_W];
                // The advance uses the tuning word that was active before
                // this tick; a freshly loaded word takes effect next tick.
                acc        <= acc_base + ftw_active;
                ftw_active <= ftw_shadow;
            end else if (sync_clr) begin
                acc <= '0;
            end
        end
    end

    // ---------------------------------------------------------------- fold
    quad_e                 quad;
    fold_t                 fold_q;
    logic [LUT_ADDR_W-1:0] rom_addr;

    assign quad     = quad_e'(p0[TOP_W-1 -: 2]);
    assign fold_q   = fold(quad);
    assign rom_addr = p0[LUT_ADDR_W-1:0] ^ {LUT_ADDR_W{fold_q.mirror}};

    // ---------------------------------------------------------------- stage 1
    logic [DATA_W-2:0] rom_q;
    logic              neg1;
    logic              v1;

    quarter_sine_rom #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .DATA_W     (DATA_W),
        .AMPLITUDE  (AMPLITUDE)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg1 <= 1'b0;
            v1   <= 1'b0;
        end else begin
            neg1 <= fold_q.neg;
            v1   <= v0;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [DATA_W-1:0] mag;
    logic              consume;

    assign mag     = {1'b0, rom_q};
    assign consume = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (v1) begin
                out_data  <= neg1 ? -mag : mag;
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
            // Set has priority over clear.
            if (v1 && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nco_sine.sv
module tb_nco_sine;

    localparam int PHASE_W    = 24;
    localparam int LUT_ADDR_W = 6;
    localparam int DATA_W     = 16;
    localparam int AMPLITUDE  = 32000;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               en = 1'b0;
    logic               sample_tick = 1'b0;
    logic [PHASE_W-1:0] ftw = '0;
    logic               ftw_we = 1'b0;
    logic [PHASE_W-1:0] phase_offset = '0;
    logic               sync_clr = 1'b0;
    logic               overrun_clr = 1'b0;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               overrun;

    nco_sine #(
        .PHASE_W    (PHASE_W),
        .LUT_ADDR_W (LUT_ADDR_W),
        .DATA_W     (DATA_W),
        .AMPLITUDE  (AMPLITUDE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sample_tick  (sample_tick),
        .ftw          (ftw),
        .ftw_we       (ftw_we),
        .phase_offset (phase_offset),
        .sync_clr     (sync_clr),
        .overrun_clr  (overrun_clr),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun)
    );

    // ------------------------------------------------------------ scoreboard
    int total = 0;
    int bad = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] cap [0:511];
    int cap_n = 0;
    bit cap_on = 1'b0;
    bit sb_on = 1'b0;

    // reference model state
    logic [PHASE_W-1:0] m_acc = '0;
    logic [PHASE_W-1:0] m_shadow = '0;
    logic [PHASE_W-1:0] m_active = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int ref_rom(input int k);
        real x;
        x = (2.0 * k + 1.0) * 3.14159265358979323846 / real'(1 << (LUT_ADDR_W + 2));
        return int'($floor(AMPLITUDE * $sin(x) + 0.5));
    endfunction

    function automatic logic [DATA_W-1:0] exp_sample(input logic [PHASE_W-1:0] p);
        logic [1:0] q;
        int i;
        int v;
        q = p[PHASE_W-1 -: 2];
        i = int'(p[PHASE_W-3 -: LUT_ADDR_W]);
        if (q[0]) i = (1 << LUT_ADDR_W) - 1 - i;
        v = ref_rom(i);
        if (q[1]) v = -v;
        return DATA_W'(v);
    endfunction

    // One clock: consume/compare whatever is offered before the edge, then
    // step to 1 time unit after the rising edge.
    task automatic cycle();
        logic [DATA_W-1:0] e;
        if (sb_on && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_unexpected observed=0x%0h expected=none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", out_data, e);
            end
            if (cap_on && cap_n < 512) begin
                cap[cap_n] = out_data;
                cap_n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ drivers
    task automatic tick(input bit clr);
        logic [PHASE_W-1:0] base;
        base = clr ? '0 : m_acc;
        exp_q.push_back(exp_sample(base + phase_offset));
        m_acc = base + m_active;
        m_active = m_shadow;
        en = 1'b1;
        sample_tick = 1'b1;
        sync_clr = clr;
        cycle();
        sample_tick = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic load_ftw(input logic [PHASE_W-1:0] val);
        ftw = val;
        ftw_we = 1'b1;
        cycle();
        ftw_we = 1'b0;
        m_shadow = val;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && exp_q.size() != 0; i++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        logic [DATA_W-1:0] t;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        logic [DATA_W-1:0] e3;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // full 256-point period
        out_ready = 1'b1;
        sb_on = 1'b1;
        load_ftw(24'h010000);
        tick(1'b0);
        idle(4);
        cap_n = 0;
        cap_on = 1'b1;
        for (int k = 0; k < 256; k++) tick(k == 0);
        drain();
        cap_on = 1'b0;
        check("period_count", cap_n, 256);
        check("period_s0", cap[0], 16'd393);
        check("period_s63", cap[63], 16'd31998);
        check("period_s128", cap[128], 16'hFE77);
        for (int k = 0; k < 128; k++) begin
            t = -cap[k + 128];
            check("sym_neg", cap[k], t);
            check("sym_mirror", cap[k], cap[127 - k]);
        end

        // latency: tick sampled at edge n, valid only after edge n+2
        idle(3);
        tick(1'b0);
        check("lat_n", out_valid, 0);
        cycle();
        check("lat_n1", out_valid, 0);
        cycle();
        check("lat_n2", out_valid, 1);
        cycle();
        check("lat_n3", out_valid, 0);

        // FTW change between ticks, then en=0 ignores ticks
        cap_n = 0;
        cap_on = 1'b1;
        tick(1'b1);
        tick(1'b0);
        load_ftw(24'h020000);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        en = 1'b0;
        sample_tick = 1'b1;
        idle(3);
        sample_tick = 1'b0;
        check("en_off_idle", out_valid, 0);
        tick(1'b0);
        drain();
        cap_on = 1'b0;
        check("ftw_idx2", cap[2], 32'(ref_rom(2)));
        check("ftw_idx3", cap[3], 32'(ref_rom(3)));
        check("ftw_idx5", cap[4], 32'(ref_rom(5)));
        check("en_hold_idx7", cap[5], 32'(ref_rom(7)));

        // 90 degree offset, zero tuning word
        load_ftw(24'h000000);
        tick(1'b0);
        idle(4);
        phase_offset = 24'h400000;
        cap_n = 0;
        cap_on = 1'b1;
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        drain();
        cap_on = 1'b0;
        check("ofs_count", cap_n, 4);
        for (int k = 0; k < 4; k++) check("ofs_value", cap[k], 16'd31998);

        // backpressure and overrun
        phase_offset = '0;
        load_ftw(24'h010000);
        tick(1'b1);
        idle(4);
        sb_on = 1'b0;
        out_ready = 1'b0;
        tick(1'b0);
        e1 = exp_q.pop_front();
        cycle();
        tick(1'b0);
        e2 = exp_q.pop_front();
        check("bp_valid1", out_valid, 1);
        check("bp_data1", out_data, e1);
        check("bp_ovr_none", overrun, 0);
        idle(2);
        check("bp_data2", out_data, e2);
        check("bp_ovr_set", overrun, 1);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check("bp_ovr_clr", overrun, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, e2);
        tick(1'b0);
        e3 = exp_q.pop_front();
        cycle();
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check("bp_set_wins", overrun, 1);
        check("bp_data3", out_data, e3);
        out_ready = 1'b1;
        cycle();
        check("bp_accept", out_valid, 0);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check("bp_ovr_clr2", overrun, 0);

        // load coincident with consumption is not an overrun
        sb_on = 1'b1;
        tick(1'b0);
        tick(1'b0);
        drain();
        check("handover_no_ovr", overrun, 0);

        // asynchronous reset with samples in flight
        sb_on = 1'b0;
        out_ready = 1'b0;
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        cycle();
        tick(1'b0);
        check("pre_rst_ovr", overrun, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_overrun", overrun, 0);
        exp_q.delete();
        m_acc = '0;
        m_shadow = '0;
        m_active = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_on = 1'b1;
        out_ready = 1'b1;
        load_ftw(24'h010000);
        cap_n = 0;
        cap_on = 1'b1;
        tick(1'b0);
        drain();
        cap_on = 1'b0;
        check("post_rst_s0", cap[0], 16'd393);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
